// File: rtl/led_event_scheduler.sv
// rtl/led_event_scheduler.sv - round-robin event-to-LED blink scheduler
// Latches event pulses, shows source g as g+1 blinks followed by a dark gap.
module led_event_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int TICK_DIV  = 1_200_000,
   parameter int ON_TICKS  = 1,
   parameter int OFF_TICKS = 1,
   parameter int GAP_TICKS = 4,
   parameter int HB_TICKS  = 8,
   localparam int IDW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic               led,
   output logic               busy,
   output logic [IDW-1:0]     grant_id,
   output logic               dropped
);

   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t             state;
   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] clr;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     pick;
   logic [IDW-1:0]     cand;
   logic               found;
   logic [7:0]         ph_cnt;
   logic [7:0]         hb_cnt;
   logic [3:0]         blinks_left;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   // Walk offsets from high to low so the nearest pending source above ptr wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr) + k) % NUM_REQ);
         if (pending[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      clr = '0;
      if (state == IDLE && tick && found)
         clr[pick] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         pending     <= '0;
         ptr         <= '0;
         grant_id    <= '0;
         ph_cnt      <= '0;
         hb_cnt      <= '0;
         blinks_left <= '0;
         led         <= 1'b0;
         busy        <= 1'b0;
         dropped     <= 1'b0;
      end else begin
         pending  <= (pending & ~clr) | req;
         dropped  <= |(req & pending & ~clr);
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (found) begin
                     grant_id    <= pick;
                     ptr         <= (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                     blinks_left <= 4'(pick) + 4'd1;
                     ph_cnt      <= '0;
                     led         <= 1'b1;
                     busy        <= 1'b1;
                     state       <= ON;
                  end else if (HB_TICKS > 0) begin
                     if (hb_cnt == 8'(HB_TICKS - 1)) begin
                        hb_cnt <= '0;
                        led    <= ~led;
                     end else begin
                        hb_cnt <= hb_cnt + 8'd1;
                     end
                  end
               end
               ON: begin
                  if (ph_cnt == 8'(ON_TICKS - 1)) begin
                     led    <= 1'b0;
                     ph_cnt <= '0;
                     state  <= OFF;
                  end else begin
                     ph_cnt <= ph_cnt + 8'd1;
                  end
               end
               OFF: begin
                  if (ph_cnt == 8'(OFF_TICKS - 1)) begin
                     ph_cnt <= '0;
                     if (blinks_left > 4'd1) begin
                        blinks_left <= blinks_left - 4'd1;
                        led         <= 1'b1;
                        state       <= ON;
                     end else begin
                        state <= GAP;
                     end
                  end else begin
                     ph_cnt <= ph_cnt + 8'd1;
                  end
               end
               GAP: begin
                  if (ph_cnt == 8'(GAP_TICKS - 1)) begin
                     ph_cnt <= '0;
                     hb_cnt <= '0;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     ph_cnt <= ph_cnt + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
